// File: rtl/mm_pkg.sv
// Shared types and fixed widths for the matrix-vector row sequencer.
package mm_pkg;

   localparam int unsigned NUM = 16;
   localparam int unsigned DW  = 32;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

endpackage

// File: rtl/mv_row_sequencer.sv
// Streams N matrix rows into the 16-lane dot-product unit and writes each
// scalar result back in order; the unit latency is discovered by counting results.
module mv_row_sequencer
   import mm_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_W:0]       row_count,
   input  logic [ADDR_W-1:0]     mat_base,
   input  logic [ADDR_W-1:0]     res_base,
   input  logic [DW*NUM-1:0]     vec_in,
   output logic                  mat_rd_en,
   output logic [ADDR_W-1:0]     mat_rd_addr,
   input  logic [DW*NUM-1:0]     mat_rd_data,
   output logic [DW*NUM-1:0]     dp_matrix,
   output logic [DW*NUM-1:0]     dp_vector,
   output logic                  dp_in_valid,
   input  logic [DW-1:0]         dp_result,
   input  logic                  dp_result_valid,
   output logic                  res_wr_en,
   output logic [ADDR_W-1:0]     res_wr_addr,
   output logic [DW-1:0]         res_wr_data,
   output logic                  busy,
   output logic                  done,
   output logic                  err_overflow
);

   localparam int unsigned CW = ADDR_W + 1;

   state_t                state_q, state_n;
   logic [CW-1:0]         n_q, n_n;
   logic [CW-1:0]         issue_q, issue_n;
   logic [CW-1:0]         rcv_q, rcv_n;
   logic [ADDR_W-1:0]     mat_base_q, mat_base_n;
   logic [ADDR_W-1:0]     res_base_q, res_base_n;
   logic [DW*NUM-1:0]     vec_q, vec_n;
   logic                  rd_en_q, rd_en_n;
   logic [ADDR_W-1:0]     rd_addr_q, rd_addr_n;
   logic                  in_valid_q, in_valid_n;
   logic                  wr_en_q, wr_en_n;
   logic [ADDR_W-1:0]     wr_addr_q, wr_addr_n;
   logic [DW-1:0]         wr_data_q, wr_data_n;
   logic                  busy_q, busy_n;
   logic                  done_q, done_n;
   logic                  err_q, err_n;
   logic                  result_ok;
   logic                  last_result;

   assign result_ok   = dp_result_valid && (state_q == ISSUE || state_q == DRAIN) && (rcv_q != n_q);
   assign last_result = result_ok && ((rcv_q + CW'(1)) == n_q);

   // Next-state and registered-output logic.
   always_comb begin
      state_n    = state_q;
      n_n        = n_q;
      issue_n    = issue_q;
      rcv_n      = rcv_q;
      mat_base_n = mat_base_q;
      res_base_n = res_base_q;
      vec_n      = vec_q;
      rd_en_n    = 1'b0;
      rd_addr_n  = rd_addr_q;
      in_valid_n = rd_en_q;
      wr_en_n    = 1'b0;
      wr_addr_n  = wr_addr_q;
      wr_data_n  = wr_data_q;
      done_n     = 1'b0;
      err_n      = err_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               n_n        = row_count;
               mat_base_n = mat_base;
               res_base_n = res_base;
               vec_n      = vec_in;
               issue_n    = '0;
               rcv_n      = '0;
               err_n      = 1'b0;
               if (row_count == '0) begin
                  state_n = DONE;
                  done_n  = 1'b1;
               end else begin
                  state_n   = ISSUE;
                  rd_en_n   = 1'b1;
                  rd_addr_n = mat_base;
                  issue_n   = CW'(1);
               end
            end
         end
         ISSUE: begin
            if (issue_q == n_q) begin
               state_n = DRAIN;
            end else begin
               rd_en_n   = 1'b1;
               rd_addr_n = mat_base_q + issue_q[ADDR_W-1:0];
               issue_n   = issue_q + CW'(1);
            end
         end
         DRAIN: begin
            if (last_result || rcv_q == n_q) begin
               state_n = DONE;
               done_n  = 1'b1;
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      // Results land in order, so the receive count doubles as the write offset.
      if (result_ok) begin
         wr_en_n   = 1'b1;
         wr_addr_n = res_base_q + rcv_q[ADDR_W-1:0];
         wr_data_n = dp_result;
         rcv_n     = rcv_q + CW'(1);
      end else if (dp_result_valid) begin
         err_n = 1'b1;
      end

      busy_n = (state_n != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         n_q        <= '0;
         issue_q    <= '0;
         rcv_q      <= '0;
         mat_base_q <= '0;
         res_base_q <= '0;
         vec_q      <= '0;
         rd_en_q    <= 1'b0;
         rd_addr_q  <= '0;
         in_valid_q <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_n;
         n_q        <= n_n;
         issue_q    <= issue_n;
         rcv_q      <= rcv_n;
         mat_base_q <= mat_base_n;
         res_base_q <= res_base_n;
         vec_q      <= vec_n;
         rd_en_q    <= rd_en_n;
         rd_addr_q  <= rd_addr_n;
         in_valid_q <= in_valid_n;
         wr_en_q    <= wr_en_n;
         wr_addr_q  <= wr_addr_n;
         wr_data_q  <= wr_data_n;
         busy_q     <= busy_n;
         done_q     <= done_n;
         err_q      <= err_n;
      end
   end

   // Row data is already aligned with dp_in_valid by the buffer's read latency.
   assign dp_matrix    = mat_rd_data;
   assign dp_vector    = vec_q;
   assign mat_rd_en    = rd_en_q;
   assign mat_rd_addr  = rd_addr_q;
   assign dp_in_valid  = in_valid_q;
   assign res_wr_en    = wr_en_q;
   assign res_wr_addr  = wr_addr_q;
   assign res_wr_data  = wr_data_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign err_overflow = err_q;

endmodule

// File: tb/tb_mv_row_sequencer.sv
// Bench for mv_row_sequencer: row-buffer and latency-10 dot-product stubs,
// a cycle-relative timing model and an in-order result scoreboard.
module tb_mv_row_sequencer;
   import mm_pkg::*;

   localparam int unsigned AW  = 10;
   localparam int unsigned CW  = AW + 1;
   localparam int unsigned VW  = DW * NUM;
   localparam int unsigned CHW = 512;
   localparam int unsigned LAT = 10;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic [CW-1:0]  row_count;
   logic [AW-1:0]  mat_base, res_base;
   logic [VW-1:0]  vec_in;
   logic           mat_rd_en;
   logic [AW-1:0]  mat_rd_addr;
   logic [VW-1:0]  mat_rd_data;
   logic [VW-1:0]  dp_matrix, dp_vector;
   logic           dp_in_valid;
   logic [DW-1:0]  dp_result;
   logic           dp_result_valid;
   logic           res_wr_en;
   logic [AW-1:0]  res_wr_addr;
   logic [DW-1:0]  res_wr_data;
   logic           busy, done, err_overflow;

   mv_row_sequencer #(.ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .row_count(row_count),
      .mat_base(mat_base), .res_base(res_base), .vec_in(vec_in),
      .mat_rd_en(mat_rd_en), .mat_rd_addr(mat_rd_addr), .mat_rd_data(mat_rd_data),
      .dp_matrix(dp_matrix), .dp_vector(dp_vector), .dp_in_valid(dp_in_valid),
      .dp_result(dp_result), .dp_result_valid(dp_result_valid),
      .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data),
      .busy(busy), .done(done), .err_overflow(err_overflow)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [CHW-1:0] act, input logic [CHW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Integer-valued FP32 helpers; all bench data is small whole numbers.
   function automatic logic [DW-1:0] i2fp(input int n);
      int e;
      int mant;
      if (n == 0) return '0;
      e = 0;
      for (int b = 0; b < 31; b++) if (n[b]) e = b;
      mant = (n << (23 - e)) & 32'h7F_FFFF;
      return {1'b0, 8'(127 + e), 23'(mant)};
   endfunction

   function automatic int fp2i(input logic [DW-1:0] f);
      int e;
      int m;
      if (f == '0) return 0;
      e = int'(f[30:23]) - 127;
      m = int'({1'b1, f[22:0]});
      return m >> (23 - e);
   endfunction

   function automatic logic [DW-1:0] dot(input logic [VW-1:0] m, input logic [VW-1:0] v);
      int s;
      s = 0;
      for (int k = 0; k < NUM; k++) s += fp2i(m[k*DW +: DW]) * fp2i(v[k*DW +: DW]);
      return i2fp(s);
   endfunction

   // Row buffer with one-cycle read latency.
   logic [VW-1:0] mem [1024];
   always @(posedge clk) if (mat_rd_en) mat_rd_data <= mem[mat_rd_addr];

   // Dot-product unit with fixed latency and no reset.
   logic          pv [LAT];
   logic [DW-1:0] pd [LAT];
   initial for (int k = 0; k < LAT; k++) begin pv[k] = 1'b0; pd[k] = '0; end
   always @(posedge clk) begin
      pv[0] <= dp_in_valid;
      pd[0] <= dot(dp_matrix, dp_vector);
      for (int k = 1; k < LAT; k++) begin
         pv[k] <= pv[k-1];
         pd[k] <= pd[k-1];
      end
   end
   assign dp_result_valid = pv[LAT-1];
   assign dp_result       = pd[LAT-1];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   bit            cmp_en = 1'b0;
   bit            op_active = 1'b0;
   int            op_s, op_n;
   logic [AW-1:0] op_mb;
   logic [VW-1:0] op_vec;
   int            err_exp = -1;
   logic [AW-1:0] exp_wa [$];
   logic [DW-1:0] exp_wd [$];
   logic [AW-1:0] obs_ra [$];
   logic [AW-1:0] obs_wa [$];
   logic [DW-1:0] last_wd;

   // Per-cycle compare against the timing rules and result scoreboard.
   always @(negedge clk) begin : cmp
      int            rel;
      bit            exp_done;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      if (cmp_en) begin
         rel = cyc - op_s;
         if (err_exp >= 0 && !(op_active && rel == 0))
            chk("err_overflow", CHW'(err_overflow), CHW'(err_exp));
         if (op_active) begin
            chk("mat_rd_en", CHW'(mat_rd_en), CHW'(rel >= 1 && rel <= op_n));
            if (mat_rd_en) begin
               chk("mat_rd_addr", CHW'(mat_rd_addr), CHW'(AW'(op_mb + rel - 1)));
               obs_ra.push_back(mat_rd_addr);
            end
            chk("dp_in_valid", CHW'(dp_in_valid), CHW'(rel >= 2 && rel <= op_n + 1));
            if (dp_in_valid) chk("dp_matrix", CHW'(dp_matrix), CHW'(mem[AW'(op_mb + rel - 2)]));
            if (rel >= 1) chk("dp_vector", CHW'(dp_vector), CHW'(op_vec));
            chk("busy", CHW'(busy), CHW'(rel >= 1));
            exp_done = (op_n == 0) && (rel == 1);
            if (res_wr_en) begin
               if (exp_wa.size() == 0) begin
                  chk("extra_write", CHW'(1), CHW'(0));
               end else begin
                  wa = exp_wa.pop_front();
                  wd = exp_wd.pop_front();
                  chk("res_wr_addr", CHW'(res_wr_addr), CHW'(wa));
                  chk("res_wr_data", CHW'(res_wr_data), CHW'(wd));
                  obs_wa.push_back(res_wr_addr);
                  last_wd = res_wr_data;
                  if (exp_wa.size() == 0) exp_done = 1'b1;
               end
            end
            chk("done", CHW'(done), CHW'(exp_done));
            if (done || exp_done) op_active = 1'b0;
         end else begin
            chk("idle_rd_en", CHW'(mat_rd_en), CHW'(0));
            chk("idle_in_valid", CHW'(dp_in_valid), CHW'(0));
            chk("idle_wr_en", CHW'(res_wr_en), CHW'(0));
            chk("idle_done", CHW'(done), CHW'(0));
            chk("idle_busy", CHW'(busy), CHW'(0));
         end
      end
   end

   task automatic begin_op(input int n, input int mb, input int rb, input logic [VW-1:0] v);
      exp_wa.delete(); exp_wd.delete(); obs_ra.delete(); obs_wa.delete();
      for (int i = 0; i < n; i++) begin
         exp_wa.push_back(AW'(rb + i));
         exp_wd.push_back(dot(mem[AW'(mb + i)], v));
      end
      @(posedge clk); #2;
      row_count = CW'(n); mat_base = AW'(mb); res_base = AW'(rb); vec_in = v; start = 1'b1;
      op_s = cyc; op_n = n; op_mb = AW'(mb); op_vec = v; err_exp = 0; op_active = 1'b1;
   endtask

   task automatic run_op(input int n, input int mb, input int rb, input logic [VW-1:0] v, input int ign);
      begin_op(n, mb, rb, v);
      for (int t = 0; t < 400 && op_active; t++) begin
         @(posedge clk); #2;
         start = (ign >= 0 && cyc - op_s == ign);
         if (start) begin
            row_count = CW'(3); mat_base = AW'(500); res_base = AW'(600);
            vec_in = {NUM{32'h4040_0000}};
         end
      end
      start = 1'b0;
      if (op_active) begin
         chk("done_timeout", CHW'(1), CHW'(0));
         op_active = 1'b0;
      end
      chk("read_count", CHW'(obs_ra.size()), CHW'(n));
      chk("write_count", CHW'(obs_wa.size()), CHW'(n));
      repeat (LAT + 5) @(posedge clk);
      #2;
   endtask

   logic [VW-1:0] ones;
   logic [AW-1:0] a;

   initial begin
      rst = 1'b1; start = 1'b0; row_count = '0; mat_base = '0; res_base = '0; vec_in = '0;
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      ones = {NUM{32'h3F80_0000}};

      chk("fp_one", CHW'(i2fp(1)), CHW'(32'h3F80_0000));
      chk("fp_32", CHW'(i2fp(32)), CHW'(32'h4200_0000));
      chk("fp_112", CHW'(i2fp(112)), CHW'(32'h42E0_0000));

      repeat (3) @(posedge clk);
      #2;
      chk("rst_rd_en", CHW'(mat_rd_en), CHW'(0));
      chk("rst_busy", CHW'(busy), CHW'(0));
      chk("rst_done", CHW'(done), CHW'(0));
      chk("rst_err", CHW'(err_overflow), CHW'(0));
      chk("rst_vec", CHW'(dp_vector), CHW'(0));
      chk("rst_wr_en", CHW'(res_wr_en), CHW'(0));
      rst = 1'b0; err_exp = 0; cmp_en = 1'b1;
      @(posedge clk); #2;

      // Single row: sixteen 1.0 times sixteen 2.0.
      mem[5] = ones;
      run_op(1, 5, 9, {NUM{32'h4000_0000}}, -1);
      a = obs_ra.size() > 0 ? obs_ra[0] : '1;
      chk("n1_read_addr", CHW'(a), CHW'(5));
      a = obs_wa.size() > 0 ? obs_wa[0] : '1;
      chk("n1_write_addr", CHW'(a), CHW'(9));
      chk("n1_write_data", CHW'(last_wd), CHW'(32'h4200_0000));

      // Eight rows, row i holds all i.0.
      for (int i = 0; i < 8; i++) mem[i] = {NUM{i2fp(i)}};
      run_op(8, 0, 100, ones, -1);
      a = obs_wa.size() == 8 ? obs_wa[7] : '1;
      chk("n8_last_addr", CHW'(a), CHW'(107));
      chk("n8_last_data", CHW'(last_wd), CHW'(32'h42E0_0000));

      // Address wrap on both buffers.
      mem[1022] = {NUM{i2fp(3)}};
      mem[1023] = {NUM{i2fp(4)}};
      run_op(4, 1022, 1023, ones, -1);
      if (obs_ra.size() == 4 && obs_wa.size() == 4) begin
         chk("wrap_ra2", CHW'(obs_ra[2]), CHW'(0));
         chk("wrap_ra3", CHW'(obs_ra[3]), CHW'(1));
         chk("wrap_wa0", CHW'(obs_wa[0]), CHW'(1023));
         chk("wrap_wa1", CHW'(obs_wa[1]), CHW'(0));
         chk("wrap_wa3", CHW'(obs_wa[3]), CHW'(2));
      end else begin
         chk("wrap_counts", CHW'(obs_ra.size() + obs_wa.size()), CHW'(8));
      end

      // Zero rows: done in cycle 1, nothing read or written.
      run_op(0, 7, 7, ones, -1);
      chk("n0_err", CHW'(err_overflow), CHW'(0));

      // Start pulse during ISSUE must be ignored.
      run_op(8, 0, 100, ones, 3);
      a = obs_wa.size() > 0 ? obs_wa[0] : '1;
      chk("ign_first_wa", CHW'(a), CHW'(100));

      // Reset during DRAIN with three results still in flight.
      begin_op(8, 0, 200, ones);
      for (int t = 0; t < 40 && cyc != op_s + 16; t++) begin
         @(posedge clk); #2;
         start = 1'b0;
      end
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0; op_active = 1'b0; err_exp = -1;
      exp_wa.delete(); exp_wd.delete();
      chk("rstmid_rd_en", CHW'(mat_rd_en), CHW'(0));
      chk("rstmid_rd_addr", CHW'(mat_rd_addr), CHW'(0));
      chk("rstmid_wr_en", CHW'(res_wr_en), CHW'(0));
      chk("rstmid_wr_addr", CHW'(res_wr_addr), CHW'(0));
      chk("rstmid_busy", CHW'(busy), CHW'(0));
      chk("rstmid_done", CHW'(done), CHW'(0));
      chk("rstmid_vec", CHW'(dp_vector), CHW'(0));
      chk("rstmid_err", CHW'(err_overflow), CHW'(0));
      chk("rstmid_writes", CHW'(obs_wa.size()), CHW'(4));
      repeat (6) @(posedge clk);
      #2;
      chk("stale_err", CHW'(err_overflow), CHW'(1));
      err_exp = 1;
      repeat (3) @(posedge clk);
      #2;

      // Recovery run clears the sticky error.
      run_op(2, 10, 20, ones, -1);
      chk("recover_err", CHW'(err_overflow), CHW'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mv_row_sequencer.md
Name: mv_row_sequencer

Overview:
- Sequences the 16-lane floating-point dot-product unit for a matrix-vector multiply of up to 2^ADDR_W rows.
- Latches the dense vector at start, streams one matrix row per cycle from the row buffer into the unit, and writes each scalar result to the result buffer.
- Pulses done when the last result has been written.
- Sits between the MM instruction decoder (start/config) and the dot-product unit plus its row/result BRAMs.

Parameters:
- NUM, 16, lanes per row; the dot-product unit is fixed at 16.
- DW, 32, element width in bits (FP32).
- ADDR_W, 10, row/result buffer address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  one-cycle command pulse; ignored unless idle
- row_count  in  ADDR_W+1  number of rows N, 0..2^ADDR_W; sampled at start
- mat_base  in  ADDR_W  first row address; sampled at start
- res_base  in  ADDR_W  first result address; sampled at start
- vec_in  in  DW*NUM  vector operand; sampled at start
- mat_rd_en  out  1  row buffer read enable
- mat_rd_addr  out  ADDR_W  row buffer read address
- mat_rd_data  in  DW*NUM  row data, valid 1 cycle after mat_rd_en
- dp_matrix  out  DW*NUM  to dot-product matrix_vector_input
- dp_vector  out  DW*NUM  to dot-product vector_input (latched vec_in)
- dp_in_valid  out  1  to dot-product input_valid
- dp_result  in  DW  from dot-product matrix_vector_output
- dp_result_valid  in  1  from dot-product add_valid
- res_wr_en  out  1  result buffer write enable
- res_wr_addr  out  ADDR_W  result address
- res_wr_data  out  DW  result data
- busy  out  1  high from the cycle after an accepted start through the done cycle
- done  out  1  one-cycle completion pulse
- err_overflow  out  1  sticky error; set on an unexpected result; cleared by rst or an accepted start

Behaviour:
- Reset: clk rising edge, synchronous, active-high (rst).
  - All outputs 0; state IDLE; counters 0.
  - vec register and dp_vector are 0.
- Row flow: the dot-product unit has no backpressure and a fixed latency L. The sequencer counts results and never assumes a value for L.
- States:
  - IDLE
    - start=1 latches the config and vec_in.
    - N>0 -> ISSUE; N=0 -> DONE.
  - ISSUE
    - mat_rd_en=1 every cycle.
    - mat_rd_addr = mat_base + issue_cnt, modulo 2^ADDR_W; wraps silently.
    - After N reads -> DRAIN.
  - DRAIN: waits until rcv_cnt==N, then -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- Timing, with start sampled in cycle 0:
  - mat_rd_en is high in cycles 1..N.
  - dp_in_valid is mat_rd_en delayed by 1, high in cycles 2..N+1.
  - dp_matrix = mat_rd_data, passed straight through.
- Result path:
  - On each dp_result_valid in a busy state, the cycle after: res_wr_en=1, res_wr_data=dp_result, res_wr_addr = res_base + rcv_cnt (mod 2^ADDR_W); rcv_cnt increments.
  - Results are in order, so rows map to addresses in order.
- done:
  - Asserted in the same cycle as the Nth res_wr_en; busy falls the following cycle.
  - For N=0, done is in cycle 1 with no reads and no writes.
- start while busy: ignored; no state change, config unchanged.
- dp_result_valid in IDLE or DONE, or when rcv_cnt==N: no write, sets err_overflow. This covers stale results in flight across rst.
- rst mid-operation: immediate return to IDLE; no done pulse; in-flight results are dropped per the rule above.
- Counters are ADDR_W+1 bits so N=2^ADDR_W is representable.

Decomposition:
- Package mm_pkg holds:
  - state enum {IDLE, ISSUE, DRAIN, DONE}
  - localparam NUM=16, DW=32
- No sub-module; the single FSM with issue and receive counters is small enough.
- The dot-product unit and the buffers are instantiated by the parent, not inside this block.

Test Plan:
- The bench models the dot-product unit with latency 10 and a row buffer with 1-cycle read latency.
- Single row: N=1, mat_base=5, res_base=9, row = sixteen 1.0, vec = sixteen 2.0 -> one read at addr 5, dp_in_valid in cycle 2, write 32.0 to addr 9, done in the same cycle as the write, busy low the next cycle.
- N=8, mat_base=0, res_base=100, row i = all i.0, vec = all 1.0 -> reads at addr 0..7 on consecutive cycles, writes 16*i to addr 100+i in order, exactly 8 writes, one done pulse.
- Wrap: ADDR_W=10, mat_base=1022, res_base=1023, N=4 -> read addrs 1022, 1023, 0, 1; write addrs 1023, 0, 1, 2.
- N=0 -> no mat_rd_en and no res_wr_en, done in cycle 1, err_overflow stays 0.
- start pulse during ISSUE of N=8 -> ignored: still exactly 8 reads, 8 writes, one done, and addresses use the original bases.
- rst asserted in DRAIN with 3 results in flight -> outputs 0 next cycle, no res_wr_en, and err_overflow=1 when the stale results arrive. A subsequent start clears err_overflow and completes normally.
